// File: rtl/spi_exe_pkg.sv
// Shared definitions for the SPI execution unit: transmit FSM states and
// a helper for sizing the down/up counters.
package spi_exe_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    HOLD     = 2'd3
  } spi_tx_state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_tx_parity_gen.sv
// Combinational even-parity generator: 1 when the word has an odd number of ones.
module spi_tx_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  always_comb begin
    parity = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      parity = parity ^ data[i];
    end
  end

endmodule

// File: rtl/spi_tx_parity_ctrl.sv
// SPI mode-0 transmit controller: accepts a word, shifts it MSB-first with an
// optional trailing even-parity bit (enabled by defining SPI_TX_PARITY_EN).
module spi_tx_parity_ctrl
  import spi_exe_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_parity
);

`ifdef SPI_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam int BIT_W = cnt_width(NBITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  spi_tx_state_e    state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [NBITS-1:0] shreg_reg, shreg_next;
  logic [NBITS-1:0] load_word;

  logic ready_reg, ready_next;
  logic sclk_reg, sclk_next;
  logic mosi_reg, mosi_next;
  logic cs_n_reg, cs_n_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic accept;

  assign accept = i_valid & ready_reg;

`ifdef SPI_TX_PARITY_EN
  logic word_par;
  logic parity_reg, parity_next;

  spi_tx_parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity (
    .data   (i_data),
    .parity (word_par)
  );

  // Parity rides in the LSB position so it is shifted out after the data LSB.
  assign load_word = {i_data, word_par};

  always_comb begin
    parity_next = parity_reg;
    if (state_reg == IDLE && accept) begin
      parity_next = word_par;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= parity_next;
    end
  end

  assign o_parity = parity_reg;
`else
  assign load_word = i_data;
  assign o_parity  = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    done_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          shreg_next   = load_word;
          bit_cnt_next = BIT_LAST;
          div_cnt_next = '0;
          state_next   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          state_next   = SHIFT_HI;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          if (bit_cnt_reg == '0) begin
            state_next = HOLD;
          end else begin
            // Shift only on the falling SCLK transition so MOSI is stable while high.
            shreg_next   = {shreg_reg[NBITS-2:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 1'b1;
            state_next   = SHIFT_LO;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          done_next    = 1'b1;
          state_next   = IDLE;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    ready_next = (state_next == IDLE);
    cs_n_next  = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
    sclk_next  = (state_next == SHIFT_HI);
    mosi_next  = (state_next == IDLE) ? 1'b0 : shreg_next[NBITS-1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      ready_reg   <= 1'b1;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      cs_n_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      ready_reg   <= ready_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      cs_n_reg    <= cs_n_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign o_ready = ready_reg;
  assign o_sclk  = sclk_reg;
  assign o_mosi  = mosi_reg;
  assign o_cs_n  = cs_n_reg;
  assign o_busy  = busy_reg;
  assign o_done  = done_reg;

endmodule

// File: tb/tb_spi_tx_parity_ctrl.sv
// Directed bench for spi_tx_parity_ctrl (DATA_W=8, CLK_DIV=2); expectations
// follow SPI_TX_PARITY_EN when it is defined for the build.
module tb_spi_tx_parity_ctrl;

`ifdef SPI_TX_PARITY_EN
  localparam bit PAR_EN    = 1'b1;
  localparam int NB        = 9;
  localparam int FRAME_LEN = 38;
`else
  localparam bit PAR_EN    = 1'b0;
  localparam int NB        = 8;
  localparam int FRAME_LEN = 34;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, o_sclk, o_mosi, o_cs_n, o_busy, o_done, o_parity;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  spi_tx_parity_ctrl #(
    .DATA_W  (8),
    .CLK_DIV (2)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_sclk   (o_sclk),
    .o_mosi   (o_mosi),
    .o_cs_n   (o_cs_n),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_parity (o_parity)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the falling edge of the first cycle after the accept edge; returns
  // at the falling edge of the o_done cycle (or after a bounded wait).
  task automatic watch_frame(input string tag, input logic [7:0] d, input logic p,
                             input bit inject);
    logic [8:0] got_bits = '0;
    logic [8:0] exp_bits;
    logic       exp_p;
    int         low = 0;
    int         rises = 0;
    bit         stable = 1'b1;
    bit         seen_done = 1'b0;
    logic       prev_sclk = 1'b0;
    logic       prev_mosi = 1'b0;

    exp_p    = PAR_EN ? p : 1'b0;
    exp_bits = PAR_EN ? {d, p} : {1'b0, d};

    check({tag, "_start_csn"},   32'(o_cs_n),  32'd0);
    check({tag, "_start_busy"},  32'(o_busy),  32'd1);
    check({tag, "_start_ready"}, 32'(o_ready), 32'd0);
    check({tag, "_start_msb"},   32'(o_mosi),  32'(d[7]));

    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (inject && c == 4) begin
        i_data  = 8'h11;
        i_valid = 1'b1;
      end
      if (inject && c == 6) check({tag, "_busy_ready"}, 32'(o_ready), 32'd0);
      if (inject && c == 20) i_valid = 1'b0;

      if (o_cs_n == 1'b0) begin
        low++;
        if (o_sclk && !prev_sclk) begin
          rises++;
          got_bits = {got_bits[7:0], o_mosi};
        end
        if (c > 0 && o_mosi !== prev_mosi && !(prev_sclk && !o_sclk)) stable = 1'b0;
      end
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
      if (o_done) seen_done = 1'b1;
      else @(negedge i_clk);
    end

    check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    check({tag, "_cs_low"},    32'(low),       32'(FRAME_LEN));
    check({tag, "_rises"},     32'(rises),     32'(NB));
    check({tag, "_bits"},      32'(got_bits),  32'(exp_bits));
    check({tag, "_mosi_stable"}, 32'(stable),  32'd1);
    check({tag, "_parity"},    32'(o_parity),  32'(exp_p));
    check({tag, "_end_csn"},   32'(o_cs_n),    32'd1);
    check({tag, "_end_ready"}, 32'(o_ready),   32'd1);
    check({tag, "_end_mosi"},  32'(o_mosi),    32'd0);
  endtask

  // Present a word for one cycle and leave the bench at the first frame cycle.
  task automatic accept_word(input logic [7:0] d, input bit keep_valid, input logic [7:0] after);
    i_data  = d;
    i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_data  = after;
    i_valid = keep_valid;
  endtask

  task automatic done_one_cycle(input string tag);
    @(negedge i_clk);
    check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_ready",  32'(o_ready),  32'd1);
    check("rst_sclk",   32'(o_sclk),   32'd0);
    check("rst_mosi",   32'(o_mosi),   32'd0);
    check("rst_csn",    32'(o_cs_n),   32'd1);
    check("rst_busy",   32'(o_busy),   32'd0);
    check("rst_done",   32'(o_done),   32'd0);
    check("rst_parity", 32'(o_parity), 32'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // 0xA5: four ones, even parity
    accept_word(8'hA5, 1'b0, 8'h5A);
    watch_frame("a5", 8'hA5, 1'b0, 1'b0);
    done_one_cycle("a5");

    // 0x07: three ones, odd parity
    repeat (2) @(negedge i_clk);
    accept_word(8'h07, 1'b0, 8'hFF);
    watch_frame("07", 8'h07, 1'b1, 1'b0);
    done_one_cycle("07");

    // Back-to-back: second word taken in the o_done cycle
    repeat (2) @(negedge i_clk);
    accept_word(8'h3C, 1'b1, 8'hFF);
    watch_frame("3c", 8'h3C, 1'b0, 1'b0);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data  = 8'h00;
    watch_frame("ff", 8'hFF, 1'b0, 1'b0);
    done_one_cycle("ff");

    // Valid held mid-frame must be ignored
    repeat (2) @(negedge i_clk);
    accept_word(8'hC3, 1'b0, 8'h00);
    watch_frame("inj", 8'hC3, 1'b0, 1'b1);
    done_one_cycle("inj");

    // Reset during bit 4 of a 0x0B frame (odd parity, so o_parity is 1 before reset)
    repeat (2) @(negedge i_clk);
    accept_word(8'h0B, 1'b0, 8'h00);
    begin
      int  rises = 0;
      logic prev = 1'b0;
      for (int c = 0; c < 100 && rises < 4; c++) begin
        if (o_sclk && !prev) rises++;
        prev = o_sclk;
        if (rises < 4) @(negedge i_clk);
      end
      check("rstmid_reached_bit4", 32'(rises), 32'd4);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rstmid_csn",    32'(o_cs_n),   32'd1);
    check("rstmid_sclk",   32'(o_sclk),   32'd0);
    check("rstmid_mosi",   32'(o_mosi),   32'd0);
    check("rstmid_parity", 32'(o_parity), 32'd0);
    check("rstmid_busy",   32'(o_busy),   32'd0);
    i_rst = 1'b0;
    begin
      bit any_done = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if (o_done || !o_cs_n) any_done = 1'b1;
        @(negedge i_clk);
      end
      check("rstmid_no_done", 32'(any_done), 32'd0);
    end

    // 0x01 after the abort: one one, odd parity
    accept_word(8'h01, 1'b0, 8'h00);
    watch_frame("01", 8'h01, 1'b1, 1'b0);
    done_one_cycle("01");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_tx_parity_ctrl.md
# spi_tx_parity_ctrl

SPI master transmit controller for the SPI execution unit. Accepts DATA_W-bit words over a valid/ready handshake, computes the word's even-parity bit through the shared parity unit, and shifts the word plus parity out MSB-first on an SPI mode-0 bus. It owns chip-select framing and SCLK generation and sits between the command front-end and the SPI pins.

## Interface
- DATA_W, 8, payload bits per frame (≥ 2)
- CLK_DIV, 2, i_clk cycles per SCLK half-period (≥ 1)
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_data  input  DATA_W  word to transmit; sampled only on accept
- i_valid  input  1  i_data valid
- o_ready  output  1  high in IDLE only; accept = i_valid & o_ready
- o_sclk  output  1  SPI clock, idle low
- o_mosi  output  1  serial data
- o_cs_n  output  1  chip select, active-low
- o_busy  output  1  high while a frame is in progress (cs_n low)
- o_done  output  1  one-cycle pulse at frame end
- o_parity  output  1  parity of last accepted word (0 = even number of ones)

## Operation
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, HOLD.
- IDLE: o_ready=1, o_cs_n=1, o_sclk=0. On accept: load shift register with i_data, latch parity into o_parity, load bit counter with NBITS−1 (NBITS = DATA_W+1 with parity, DATA_W without), go SHIFT_LO.
- SHIFT_LO: o_cs_n=0, o_sclk=0, o_mosi = current bit (MSB first, parity bit last). After CLK_DIV cycles → SHIFT_HI.
- SHIFT_HI: o_sclk=1, o_mosi unchanged. After CLK_DIV cycles: counter 0 → HOLD; else shift, decrement counter → SHIFT_LO.
- HOLD: o_sclk=0, o_cs_n=0 for CLK_DIV cycles → IDLE with o_done=1 for that single cycle.
- i_valid while busy is ignored (no queuing). i_data may change freely after accept.
- Parity unit: even parity, 0 when count of ones is even, 1 when odd.

## Timing
- Reset values: o_ready=1, o_sclk=0, o_mosi=0, o_cs_n=1, o_busy=0, o_done=0, o_parity=0; FSM IDLE.
- All outputs registered. Accept edge = T0. From cycle after T0: o_cs_n=0, o_busy=1, o_ready=0, o_mosi=MSB.
- Frame length (cs_n low) = 2·CLK_DIV·NBITS + CLK_DIV cycles; o_done, o_cs_n=1, o_ready=1 in the next cycle.
- o_mosi changes only with SCLK falling transitions (or frame start); stable through each high phase.
- Back-to-back: accept allowed in the o_done cycle; guarantees ≥1 cycle of cs_n high between frames.
- Reset mid-frame: immediate abort to reset values, no o_done, partial frame discarded.
- o_mosi returns to 0 in IDLE.

## Configuration
- SPI_TX_PARITY_EN defined: NBITS = DATA_W+1, parity bit appended after LSB, o_parity driven as above.
- Undefined: NBITS = DATA_W, no parity bit shifted, parity unit not instantiated, o_parity tied 0.

## Structure
- Shared package spi_exe_pkg: FSM state enum typedef, function computing counter widths ($clog2 of CLK_DIV and NBITS).
- One sub-module: spi_tx_parity_gen, combinational DATA_W-input parity (popcount mod 2), instantiated only under SPI_TX_PARITY_EN.

## Test plan
- DATA_W=8, CLK_DIV=2, macro on, send 0xA5 → o_parity=0; MOSI sampled on SCLK rise = 1,0,1,0,0,1,0,1,0; cs_n low 38 cycles; o_done 1 cycle.
- Send 0x07 → o_parity=1; last sampled bit 1; nine SCLK rising edges.
- Two words 0x3C then 0xFF, i_valid held high → second accepted in o_done cycle; cs_n high exactly 1 cycle; parities 0,0.
- Hold i_valid with 0x11 mid-frame → o_ready=0, not accepted, frame in progress unaltered.
- Assert i_rst during bit 4 → next cycle o_cs_n=1, o_sclk=0, o_mosi=0, o_parity=0, no o_done; later 0x01 frame correct.
- Macro off, send 0xA5 → eight bits, cs_n low 34 cycles, o_parity stays 0.
